request_unit: RTL and testbench

- Sequences memory requests for the single-cycle datapath. Sits directly downstream of the control unit.
- Consumes the decoded dREN/dWEN/halt of the current instruction. Drives instruction- and data-memory read/write enables toward the memory arbiter.
- Issues the one-cycle PC-advance enable, latches halt, and keeps a stall watchdog plus retire/stall performance counters.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/req_watchdog.sv | 42 ++++
 rtl/request_unit.sv | 161 ++++++++++++++++
 tb/tb_request_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: request-unit sequencing states and a small
// helper that tells the watchdog which states are waiting on memory.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MEM   = 3'd2,
    HALT  = 3'd3,
    ERR   = 3'd4
  } reqstate_t;

  // States in which the unit is waiting on the arbiter for a hit
  function automatic logic wd_active(input reqstate_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/req_watchdog.sv
// Stall watchdog: counts cycles spent waiting for a memory hit and flags
// expiry once the count reaches TIMEOUT-1.
module req_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority so a hit in the expiry cycle restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer for the single-cycle datapath: fetch/data-access
// FSM, PC-advance pulse, sticky halt/error flags and performance counters.
module request_unit #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dREN_in,
  input  logic             dWEN_in,
  input  logic             halt_in,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  import cpu_types_pkg::*;

  reqstate_t        state_q, state_d;
  logic             dmem_ren_q, dmem_ren_d;
  logic             dmem_wen_q, dmem_wen_d;
  logic             halt_q, halt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             pc_en_c;
  logic             imem_ren_c;
  logic             hit_c;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expired;

  req_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state, registered-flag updates and combinational request outputs
  always_comb begin
    state_d    = state_q;
    dmem_ren_d = dmem_ren_q;
    dmem_wen_d = dmem_wen_q;
    halt_d     = halt_q;
    mem_err_d  = mem_err_q;
    pc_en_c    = 1'b0;
    imem_ren_c = 1'b0;
    hit_c      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_ren_c = 1'b1;
        hit_c      = ihit;
        if (ihit) begin
          if (halt_in) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else if (dREN_in || dWEN_in) begin
            state_d    = MEM;
            dmem_ren_d = dREN_in;
            dmem_wen_d = dWEN_in;
          end else begin
            pc_en_c = 1'b1;
          end
        end else if (wd_expired) begin
          state_d   = ERR;
          halt_d    = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        hit_c = dhit;
        if (dhit) begin
          pc_en_c    = 1'b1;
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          state_d    = FETCH;
        end else if (wd_expired) begin
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          halt_d     = 1'b1;
          mem_err_d  = 1'b1;
          state_d    = ERR;
        end else begin
          state_d = MEM;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = IDLE;
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
      end
    endcase
  end

  // Counter updates and watchdog control
  always_comb begin
    if (pc_en_c) begin
      instr_d = instr_q + CNT_W'(1);
    end else begin
      instr_d = instr_q;
    end
    if (state_q == MEM) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    wd_clr = (state_d != state_q) || hit_c;
    wd_en  = wd_active(state_q);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      halt_q     <= 1'b0;
      mem_err_q  <= 1'b0;
      instr_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      dmem_ren_q <= dmem_ren_d;
      dmem_wen_q <= dmem_wen_d;
      halt_q     <= halt_d;
      mem_err_q  <= mem_err_d;
      instr_q    <= instr_d;
      stall_q    <= stall_d;
    end
  end

  assign imemREN     = imem_ren_c;
  assign pc_en       = pc_en_c;
  assign dmemREN     = dmem_ren_q;
  assign dmemWEN     = dmem_wen_q;
  assign halt        = halt_q;
  assign mem_err     = mem_err_q;
  assign instr_count = instr_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit with TIMEOUT=4 and CNT_W=4 so that the
// watchdog and counter wrap are reachable in a few cycles.
module tb_request_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  logic             CLK;
  logic             RST;
  logic             dREN_in, dWEN_in, halt_in, ihit, dhit;
  logic             imemREN, dmemREN, dmemWEN, pc_en, halt, mem_err;
  logic [CNT_W-1:0] instr_count, stall_count;

  int n_total;
  int n_bad;

  request_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .dREN_in     (dREN_in),
    .dWEN_in     (dWEN_in),
    .halt_in     (halt_in),
    .ihit        (ihit),
    .dhit        (dhit),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .pc_en       (pc_en),
    .halt        (halt),
    .mem_err     (mem_err),
    .instr_count (instr_count),
    .stall_count (stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The control unit must never request a read and a write together
  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(dREN_in && dWEN_in))
        else $error("illegal dREN_in and dWEN_in both set");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic ih, input logic dh, input logic dr,
                        input logic dw, input logic hl);
    ihit    = ih;
    dhit    = dh;
    dREN_in = dr;
    dWEN_in = dw;
    halt_in = hl;
    #1;
  endtask

  // Two reset edges; returns in IDLE with RST low
  task automatic do_reset;
    RST = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    RST     = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset then ALU stream
    do_reset;
    check_eq("idle_imem", imemREN, 32'd0);
    check_eq("idle_pc_en", pc_en, 32'd0);
    check_eq("idle_halt", halt, 32'd0);
    check_eq("idle_err", mem_err, 32'd0);
    check_eq("idle_dren", dmemREN, 32'd0);
    check_eq("idle_icnt", instr_count, 32'd0);
    check_eq("idle_scnt", stall_count, 32'd0);
    tick;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("alu_imem", imemREN, 32'd1);
      check_eq("alu_pc_en", pc_en, 32'd1);
      tick;
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("alu_pc_en_idle", pc_en, 32'd0);
    check_eq("alu_icnt", instr_count, 32'd5);
    check_eq("alu_scnt", stall_count, 32'd0);

    // Load with 3-cycle latency; ihit during MEM is ignored
    do_reset;
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("ld_issue_pc_en", pc_en, 32'd0);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ld_dren", dmemREN, 32'd1);
    check_eq("ld_imem", imemREN, 32'd0);
    check_eq("ld_ihit_ignored", pc_en, 32'd0);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ld_dren_held", dmemREN, 32'd1);
    check_eq("ld_dhit_pc_en", pc_en, 32'd1);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ld_dren_clr", dmemREN, 32'd0);
    check_eq("ld_imem_back", imemREN, 32'd1);
    check_eq("ld_scnt", stall_count, 32'd3);
    check_eq("ld_icnt", instr_count, 32'd1);

    // Store then halt; later hits change nothing
    do_reset;
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("st_dwen", dmemWEN, 32'd1);
    tick;
    check_eq("st_dwen_held", dmemWEN, 32'd1);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("st_pc_en", pc_en, 32'd1);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("st_dwen_clr", dmemWEN, 32'd0);
    check_eq("hlt_pc_en", pc_en, 32'd0);
    tick;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("hlt_pc_en_hits", pc_en, 32'd0);
      check_eq("hlt_imem", imemREN, 32'd0);
      tick;
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hlt_halt", halt, 32'd1);
    check_eq("hlt_err", mem_err, 32'd0);
    check_eq("hlt_icnt", instr_count, 32'd1);
    check_eq("hlt_scnt", stall_count, 32'd2);

    // Watchdog expiry in MEM
    do_reset;
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    tick;
    check_eq("wd_c4_err", mem_err, 32'd0);
    check_eq("wd_c4_dren", dmemREN, 32'd1);
    tick;
    check_eq("wd_err", mem_err, 32'd1);
    check_eq("wd_halt", halt, 32'd1);
    check_eq("wd_dren", dmemREN, 32'd0);
    check_eq("wd_imem", imemREN, 32'd0);
    check_eq("wd_scnt", stall_count, 32'd4);

    // Hit on the last MEM cycle wins over the watchdog
    do_reset;
    tick;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    tick;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("wdh_pc_en", pc_en, 32'd1);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("wdh_err", mem_err, 32'd0);
    check_eq("wdh_halt", halt, 32'd0);
    check_eq("wdh_imem", imemREN, 32'd1);
    check_eq("wdh_icnt", instr_count, 32'd1);
    check_eq("wdh_scnt", stall_count, 32'd4);

    // Reset while a store is outstanding
    do_reset;
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_pre_dwen", dmemWEN, 32'd1);
    check_eq("rst_pre_icnt", instr_count, 32'd1);
    RST = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    RST = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_dwen", dmemWEN, 32'd0);
    check_eq("rst_imem", imemREN, 32'd0);
    check_eq("rst_pc_en", pc_en, 32'd0);
    check_eq("rst_icnt", instr_count, 32'd0);
    check_eq("rst_scnt", stall_count, 32'd0);
    tick;
    check_eq("rst_refetch", imemREN, 32'd1);

    // Counter wrap at CNT_W=4
    do_reset;
    tick;
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_icnt", instr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
